// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_master
// Description : MEM-stage bus master. Turns the EX/MEM load/store controls
//               into single word accesses on the data bus. It holds the
//               pipeline until each access completes and returns load data
//               for MEM/WB. A response timeout guards against a hung slave.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   aluc_i                byte address (ALU result) from EX/MEM
//   rD2_i                 store data from EX/MEM
//   ram_we_i              store request
//   rf_we_i, rf_wsel_i    register write enable / writeback source select
//   stall_o               combinational pipeline hold
//   bus_req_o, bus_we_o,
//   bus_addr_o,
//   bus_wdata_o           registered request channel
//   bus_gnt_i             slave accepts request
//   bus_rvalid_i,
//   bus_rdata_i           read response channel
//   rdata_o               last completed load result
//   err_o                 one-cycle pulse on load timeout
// ============================================================================
module mem_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] aluc_i,
  input  logic [31:0] rD2_i,
  input  logic        ram_we_i,
  input  logic        rf_we_i,
  input  logic [1:0]  rf_wsel_i,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic w_store, w_load, w_acc;

  // A store wins over a load when both are flagged.
  assign w_store = ram_we_i;
  assign w_load  = rf_we_i & (rf_wsel_i == 2'b01) & ~ram_we_i;
  assign w_acc   = w_store | w_load;

  // Only word accesses are made; the byte offset is dropped.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^aluc_i[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;       // err is a single-cycle pulse
    stall_o = 1'b1;

    case (state_q)
      S_IDLE: begin
        stall_o = w_acc;
        if (w_acc) begin
          addr_d  = {aluc_i[31:2], 2'b00};
          wdata_d = rD2_i;
          we_d    = w_store;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Request fields stay frozen until the slave grants; no timeout here.
        if (bus_gnt_i) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 8'd1;
        // rvalid takes priority over a timeout in the same cycle.
        if (bus_rvalid_i) begin
          rdata_d = bus_rdata_i;
          state_d = S_DONE;
        end else if (cnt_q == C_CNT_LAST) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        // DONE: release the pipeline for exactly this edge.
        stall_o = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_master
// Description : Directed self-checking bench for mem_bus_master. Stimulus is
//               a linear sequence of steps; outputs are sampled 1 time unit
//               after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] aluc = 32'd0;
  logic [31:0] rd2 = 32'd0;
  logic        ram_we = 1'b0;
  logic        rf_we = 1'b0;
  logic [1:0]  rf_wsel = 2'b00;
  logic        stall;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata_bus = 32'd0;
  logic [31:0] rdata;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  mem_bus_master #(
    .TIMEOUT_CYCLES(16),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .aluc_i      (aluc),
    .rD2_i       (rd2),
    .ram_we_i    (ram_we),
    .rf_we_i     (rf_we),
    .rf_wsel_i   (rf_wsel),
    .stall_o     (stall),
    .bus_req_o   (req),
    .bus_we_o    (we),
    .bus_addr_o  (addr),
    .bus_wdata_o (wdata),
    .bus_gnt_i   (gnt),
    .bus_rvalid_i(rvalid),
    .bus_rdata_i (rdata_bus),
    .rdata_o     (rdata),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_acc();
    ram_we  = 1'b0;
    rf_we   = 1'b0;
    rf_wsel = 2'b00;
  endtask

  task automatic set_load(input logic [31:0] a);
    aluc    = a;
    ram_we  = 1'b0;
    rf_we   = 1'b1;
    rf_wsel = 2'b01;
  endtask

  initial begin
    // ---------------- reset ----------------
    tick();
    chk("rst_req",   {31'd0, req},   32'd0);
    chk("rst_we",    {31'd0, we},    32'd0);
    chk("rst_addr",  addr,           32'd0);
    chk("rst_wdata", wdata,          32'd0);
    chk("rst_rdata", rdata,          32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- store, grant tied high ----------------
    gnt    = 1'b1;
    aluc   = 32'h0000_0104;
    rd2    = 32'h1234_5678;
    ram_we = 1'b1;
    #1;
    chk("st_idle_stall", {31'd0, stall}, 32'd1);
    tick();                                   // REQ
    chk("st_req",       {31'd0, req},   32'd1);
    chk("st_addr",      addr,           32'h0000_0104);
    chk("st_we",        {31'd0, we},    32'd1);
    chk("st_wdata",     wdata,          32'h1234_5678);
    chk("st_req_stall", {31'd0, stall}, 32'd1);
    tick();                                   // DONE
    chk("st_done_stall", {31'd0, stall}, 32'd0);
    chk("st_done_req",   {31'd0, req},   32'd0);
    chk("st_rdata",      rdata,          32'd0);
    no_acc();
    gnt = 1'b0;
    tick();                                   // IDLE
    chk("st_idle2_stall", {31'd0, stall}, 32'd0);

    // ---------------- load, slow slave ----------------
    set_load(32'hFFFF_F072);
    #1;
    chk("ld_idle_stall", {31'd0, stall}, 32'd1);
    tick();                                   // REQ cycle 1
    chk("ld_addr", addr,        32'hFFFF_F070);
    chk("ld_we",   {31'd0, we}, 32'd0);
    chk("ld_req",  {31'd0, req},32'd1);
    aluc = 32'h0000_0AAC;                     // fields must not follow the input
    tick();                                   // REQ cycle 2
    chk("ld_addr_hold",  addr,           32'hFFFF_F070);
    chk("ld_req_hold",   {31'd0, req},   32'd1);
    chk("ld_stall_wait", {31'd0, stall}, 32'd1);
    aluc = 32'hFFFF_F072;
    tick();                                   // REQ cycle 3
    chk("ld_addr_hold3", addr, 32'hFFFF_F070);
    gnt = 1'b1;
    tick();                                   // RESP 1
    gnt = 1'b0;
    chk("ld_resp_req",   {31'd0, req},   32'd0);
    chk("ld_resp_stall", {31'd0, stall}, 32'd1);
    tick();                                   // RESP 2
    rvalid    = 1'b1;
    rdata_bus = 32'h0000_00A5;
    tick();                                   // DONE
    rvalid = 1'b0;
    chk("ld_rdata",      rdata,          32'h0000_00A5);
    chk("ld_done_stall", {31'd0, stall}, 32'd0);
    chk("ld_err",        {31'd0, err},   32'd0);
    no_acc();
    tick();                                   // IDLE
    chk("ld_rdata_held", rdata, 32'h0000_00A5);

    // ---------------- timeout ----------------
    set_load(32'h0000_0200);
    gnt = 1'b1;
    tick();                                   // REQ
    tick();                                   // RESP 1
    gnt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_resp_stall", {31'd0, stall}, 32'd1);
      chk("to_resp_err",   {31'd0, err},   32'd0);
      if (i < 15) tick();
    end
    tick();                                   // DONE
    chk("to_rdata",      rdata,          32'hDEAD_BEEF);
    chk("to_err",        {31'd0, err},   32'd1);
    chk("to_done_stall", {31'd0, stall}, 32'd0);
    no_acc();
    tick();                                   // IDLE
    chk("to_err_pulse",  {31'd0, err},   32'd0);

    // ---------------- rvalid on the limit cycle ----------------
    set_load(32'h0000_0204);
    gnt = 1'b1;
    tick();                                   // REQ
    tick();                                   // RESP 1
    gnt = 1'b0;
    for (int i = 0; i < 15; i++) tick();      // RESP 16
    chk("bd_stall16", {31'd0, stall}, 32'd1);
    rvalid    = 1'b1;
    rdata_bus = 32'h0000_0001;
    tick();                                   // DONE
    rvalid = 1'b0;
    chk("bd_rdata", rdata,        32'h0000_0001);
    chk("bd_err",   {31'd0, err}, 32'd0);
    no_acc();
    tick();

    // ---------------- store/load conflict, then idle ----------------
    aluc    = 32'h0000_0300;
    rd2     = 32'hCAFE_F00D;
    ram_we  = 1'b1;
    rf_we   = 1'b1;
    rf_wsel = 2'b01;
    tick();                                   // REQ
    chk("cf_we",    {31'd0, we}, 32'd1);
    chk("cf_wdata", wdata,       32'hCAFE_F00D);
    gnt = 1'b1;
    tick();                                   // DONE (write path)
    gnt = 1'b0;
    chk("cf_done_stall", {31'd0, stall}, 32'd0);
    chk("cf_rdata",      rdata,          32'h0000_0001);
    no_acc();
    tick();                                   // IDLE
    tick();
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_req",   {31'd0, req},   32'd0);

    // ---------------- reset in RESP ----------------
    set_load(32'h0000_0400);
    gnt = 1'b1;
    tick();                                   // REQ
    tick();                                   // RESP
    gnt = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mr_req",   {31'd0, req}, 32'd0);
    chk("mr_rdata", rdata,        32'd0);
    no_acc();
    #1;
    chk("mr_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    rvalid    = 1'b1;
    rdata_bus = 32'h0000_0055;
    tick();
    tick();
    rvalid = 1'b0;
    chk("mr_stray_rdata", rdata,          32'd0);
    chk("mr_stray_stall", {31'd0, stall}, 32'd0);
    chk("mr_stray_req",   {31'd0, req},   32'd0);

    // A fresh store after reset still works.
    aluc   = 32'h0000_0010;
    rd2    = 32'h0BAD_F00D;
    ram_we = 1'b1;
    tick();                                   // REQ
    chk("pr_addr", addr,         32'h0000_0010);
    chk("pr_req",  {31'd0, req}, 32'd1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    no_acc();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- MEM-stage consumer of the EX/MEM pipeline register. Takes the registered ALU result, store data and memory-control bits, and turns them into word accesses on the data bus (DRAM plus the peripheral window).
- Holds the pipeline via stall_o until each access completes.
- Returns load data for the MEM/WB register.
- Handles variable-latency slaves and protects against a hung slave with a response timeout.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles waited in RESP for bus_rvalid_i before the load is aborted (legal range 2..255).
- ERR_DATA, 32'hDEAD_BEEF, value returned in rdata_o when a load times out.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- aluc_i  input  32  byte address from EX/MEM (ALU result).
- rD2_i  input  32  store data from EX/MEM.
- ram_we_i  input  1  store request from EX/MEM.
- rf_we_i  input  1  register-file write enable from EX/MEM.
- rf_wsel_i  input  2  writeback source select; 2'b01 = memory read data.
- stall_o  output  1  combinational; high = hold IF/ID/EX/MEM registers.
- bus_req_o  output  1  registered request.
- bus_we_o  output  1  registered; 1 = write, 0 = read.
- bus_addr_o  output  32  registered word address, {aluc[31:2],2'b00}.
- bus_wdata_o  output  32  registered store data.
- bus_gnt_i  input  1  slave accepts the request this cycle.
- bus_rvalid_i  input  1  read data valid.
- bus_rdata_i  input  32  read data.
- rdata_o  output  32  load result to MEM/WB; held until the next load completes.
- err_o  output  1  one-cycle pulse on load timeout.

Behaviour:
- Access decode:
  - store = ram_we_i.
  - load = rf_we_i & (rf_wsel_i==2'b01) & ~ram_we_i; a store wins if both are set.
  - acc = store | load.
- Reset (async, immediate): state=IDLE, timeout counter=0. bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, rdata_o and err_o all go to 0.
- Reset mid-access: the request is dropped immediately; no response is awaited after release; late bus_rvalid_i is ignored in IDLE.
- FSM states IDLE, REQ, RESP, DONE.
  - IDLE: stall_o = acc. If acc: latch bus_addr_o, bus_wdata_o=rD2_i and bus_we_o=store; set bus_req_o=1; go to REQ.
  - REQ: stall_o=1; bus_req_o and all bus fields held stable until bus_gnt_i.
    - On bus_gnt_i: bus_req_o<=0.
    - Write: go to DONE.
    - Read: clear counter, go to RESP.
    - No gnt: stay in REQ indefinitely (no timeout on grant).
  - RESP: stall_o=1; counter increments each cycle.
    - bus_rvalid_i: rdata_o<=bus_rdata_i, go to DONE.
    - Else, if counter==TIMEOUT_CYCLES-1: rdata_o<=ERR_DATA, err_o<=1 for one cycle, go to DONE.
    - If rvalid arrives in the same cycle as the counter limit, rvalid wins with no error.
  - DONE: stall_o=0 so the pipeline advances this edge; go to IDLE unconditionally. A new access presented afterward is seen in IDLE the next cycle; no back-to-back skip.
- bus_gnt_i and bus_rvalid_i are ignored outside REQ and RESP respectively.
- rdata_o changes only on load completion; stores leave it untouched.
- Latency (cycles from access visible in IDLE to pipeline advance):
  - Store with immediate grant: 3 (IDLE, REQ, DONE).
  - Load with grant in REQ and rvalid in first RESP cycle: 4.
- Address bits [1:0] are ignored: only word accesses are made, and no misalignment error is raised.
- Non-access cycles (ALU ops, branches) produce no stall and no bus activity.

Test Plan:
- Store: aluc_i=32'h0000_0104, rD2_i=32'h1234_5678, ram_we_i=1; gnt tied high.
  -> REQ cycle shows addr 32'h0000_0104, we=1, wdata 32'h1234_5678; stall_o high for exactly 2 cycles; rdata_o unchanged.
- Load with slow slave: aluc_i=32'hFFFF_F072, rf_we_i=1, rf_wsel_i=2'b01; gnt after 3 cycles; rvalid 2 cycles later with 32'h0000_00A5.
  -> bus_addr_o=32'hFFFF_F070; bus fields stable during wait; rdata_o=32'h0000_00A5; stall_o drops in DONE.
- Timeout: load granted, rvalid never asserted, TIMEOUT_CYCLES=16.
  -> exactly 16 RESP cycles; rdata_o=32'hDEAD_BEEF; err_o one-cycle pulse; pipeline released.
- Boundary: rvalid asserted with 32'h0000_0001 on the 16th RESP cycle.
  -> rdata_o=32'h0000_0001; err_o stays 0.
- Conflict and idle: ram_we_i=1 with rf_wsel_i=2'b01, rf_we_i=1 -> treated as a write. Then a cycle with no access -> stall_o=0, bus_req_o=0.
- Reset mid-RESP: assert rst_i while waiting, then deassert and later drive rvalid=1.
  -> bus_req_o=0 and rdata_o=0 immediately; state IDLE; the stray rvalid is ignored.
